// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers, mode constants and operation encoding
package gray_pkg;

  localparam int MAX_W     = 64;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef logic [MAX_W-1:0] wide_t;

  // Operation selected for the next clock edge, in priority order load > count > hold.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } cnt_op_e;

  // Callers zero-extend into wide_t; zero upper bits leave narrower results intact.
  function automatic wide_t bin2gray(input wide_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic wide_t gray2bin(input wide_t g);
    wide_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// rtl/gray2bin_conv.sv - combinational Gray-to-binary prefix-XOR converter
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_updown_counter_param.sv
// rtl/gray_updown_counter_param.sv - parametrised Gray/binary up/down counter
// with load, wrap-or-saturate mode and a one-cycle limit pulse.
module gray_updown_counter_param
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int SATURATE  = MODE_WRAP,
  parameter int LOAD_GRAY = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             upd_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  output logic [WIDTH-1:0] cb_o,
  output logic [WIDTH-1:0] cg_o,
  output logic             lim_o
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  logic [WIDTH-1:0] cb_q, cb_d;
  logic [WIDTH-1:0] cg_q, cg_d;
  logic             lim_q, lim_d;
  logic [WIDTH-1:0] ld_bin;
  cnt_op_e          op;

  if (LOAD_GRAY != 0) begin : g_ld_gray
    gray2bin_conv #(
      .WIDTH (WIDTH)
    ) u_ld_conv (
      .gray_i (ld_val_i),
      .bin_o  (ld_bin)
    );
  end else begin : g_ld_bin
    assign ld_bin = ld_val_i;
  end

  always_comb begin
    op = OP_HOLD;
    if (ld_i) begin
      op = OP_LOAD;
    end else if (en_i) begin
      op = upd_i ? OP_UP : OP_DOWN;
    end
  end

  always_comb begin
    cb_d  = cb_q;
    lim_d = 1'b0;
    unique case (op)
      OP_LOAD: cb_d = ld_bin;
      OP_UP: begin
        if (cb_q == CNT_MAX) begin
          lim_d = 1'b1;
          cb_d  = (SATURATE == MODE_SAT) ? cb_q : CNT_ZERO;
        end else begin
          cb_d = cb_q + 1'b1;
        end
      end
      OP_DOWN: begin
        if (cb_q == CNT_ZERO) begin
          lim_d = 1'b1;
          cb_d  = (SATURATE == MODE_SAT) ? cb_q : CNT_MAX;
        end else begin
          cb_d = cb_q - 1'b1;
        end
      end
      default: cb_d = cb_q;
    endcase
  end

  // Gray is derived from the next binary value so both outputs move together.
  always_comb begin
    cg_d = WIDTH'(bin2gray(wide_t'(cb_d)));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cb_q  <= '0;
      cg_q  <= '0;
      lim_q <= 1'b0;
    end else begin
      cb_q  <= cb_d;
      cg_q  <= cg_d;
      lim_q <= lim_d;
    end
  end

  assign cb_o  = cb_q;
  assign cg_o  = cg_q;
  assign lim_o = lim_q;

endmodule
